// File: rtl/aes_avalon_ctrl.sv
// Avalon-MM register front end for an AES decrypt core: key/ciphertext registers,
// plaintext capture, a START/DONE handshake with the core and an optional RUN timeout.
module aes_avalon_ctrl #(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic         CLK,
  input  logic         RESET_N,
  input  logic         AVL_CS,
  input  logic         AVL_READ,
  input  logic         AVL_WRITE,
  input  logic [3:0]   AVL_ADDR,
  input  logic [3:0]   AVL_BYTE_EN,
  input  logic [31:0]  AVL_WRITEDATA,
  output logic [31:0]  AVL_READDATA,
  output logic [31:0]  EXPORT_DATA,
  output logic         AES_START,
  input  logic         AES_DONE,
  output logic [127:0] AES_KEY,
  output logic [127:0] AES_MSG_ENC,
  input  logic [127:0] AES_MSG_DEC,
  output logic [1:0]   o_dbg_state
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;

  state_t      r_state, w_next;
  logic [31:0] r_regs [0:11];
  logic [31:0] r_cnt;
  logic [31:0] r_rdata;
  logic        r_ctrl, r_done, r_tmo, r_start;

  logic        w_wr, w_rd, w_ctrl_wr, w_ctrl_bit, w_busy, w_term;
  logic        w_go, w_cap, w_abort, w_tmo_evt, w_clr_done;
  logic [31:0] w_rdata;

  assign w_wr       = AVL_CS & AVL_WRITE;
  assign w_rd       = AVL_CS & AVL_READ;
  assign w_ctrl_wr  = w_wr && (AVL_ADDR == 4'd14) && AVL_BYTE_EN[0];
  assign w_ctrl_bit = AVL_WRITEDATA[0];
  assign w_busy     = (r_state == S_RUN);
  assign w_term     = (TIMEOUT != 0) && (r_cnt == TIMEOUT - 1);

  // State register
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      r_state <= S_IDLE;
      r_start <= 1'b0;
    end else begin
      r_state <= w_next;
      r_start <= (w_next == S_RUN);
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_go) w_next = S_RUN;
      S_RUN: begin
        if (w_cap)                     w_next = S_DONE;
        else if (w_abort || w_tmo_evt) w_next = S_IDLE;
      end
      S_DONE: if (w_clr_done) w_next = w_go ? S_RUN : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Event decode; AES_DONE takes priority over abort and terminal count in RUN
  always_comb begin
    w_go       = 1'b0;
    w_cap      = 1'b0;
    w_abort    = 1'b0;
    w_tmo_evt  = 1'b0;
    w_clr_done = 1'b0;
    case (r_state)
      S_IDLE: w_go = w_ctrl_wr && w_ctrl_bit;
      S_RUN: begin
        if (AES_DONE)                      w_cap     = 1'b1;
        else if (w_ctrl_wr && !w_ctrl_bit) w_abort   = 1'b1;
        else if (w_term)                   w_tmo_evt = 1'b1;
      end
      S_DONE: begin
        w_clr_done = w_ctrl_wr;
        w_go       = w_ctrl_wr && w_ctrl_bit;
      end
      default: ;
    endcase
  end

  always_comb begin
    w_rdata = '0;
    case (AVL_ADDR)
      4'd12, 4'd13: w_rdata = '0;
      4'd14:        w_rdata = {31'd0, r_ctrl};
      4'd15:        w_rdata = {29'd0, r_tmo, w_busy, r_done};
      default:      w_rdata = r_regs[AVL_ADDR];
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      for (int i = 0; i < 12; i++) r_regs[i] <= '0;
      r_cnt   <= '0;
      r_rdata <= '0;
      r_ctrl  <= 1'b0;
      r_done  <= 1'b0;
      r_tmo   <= 1'b0;
    end else begin
      if (w_rd) r_rdata <= w_rdata;

      if (w_wr && !AVL_ADDR[3] && !w_busy) begin
        for (int b = 0; b < 4; b++)
          if (AVL_BYTE_EN[b]) r_regs[AVL_ADDR][8*b +: 8] <= AVL_WRITEDATA[8*b +: 8];
      end

      if (w_cap) begin
        r_regs[8]  <= AES_MSG_DEC[127:96];
        r_regs[9]  <= AES_MSG_DEC[95:64];
        r_regs[10] <= AES_MSG_DEC[63:32];
        r_regs[11] <= AES_MSG_DEC[31:0];
      end

      if (w_go)                r_cnt <= '0;
      else if (w_busy)         r_cnt <= r_cnt + 32'd1;

      if (w_tmo_evt)           r_ctrl <= 1'b0;
      else if (w_ctrl_wr)      r_ctrl <= w_ctrl_bit;

      if (w_go || w_clr_done)  r_done <= 1'b0;
      else if (w_cap)          r_done <= 1'b1;

      if (w_go)                r_tmo <= 1'b0;
      else if (w_tmo_evt)      r_tmo <= 1'b1;
    end
  end

  assign AVL_READDATA = r_rdata;
  assign AES_START    = r_start;
  assign EXPORT_DATA  = {r_regs[0][31:16], r_regs[3][15:0]};
  assign AES_KEY      = {r_regs[0], r_regs[1], r_regs[2], r_regs[3]};
  assign AES_MSG_ENC  = {r_regs[4], r_regs[5], r_regs[6], r_regs[7]};
  assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_aes_avalon_ctrl.sv
// Directed bench: one controller at the default timeout and one at TIMEOUT=16 share
// the Avalon bus, each with its own core-done stub.
module tb_aes_avalon_ctrl;

  logic         clk, rst_n;
  logic         cs, rd, wr;
  logic [3:0]   addr, be;
  logic [31:0]  wdata;
  logic         done_a, done_b;
  logic [127:0] msg_dec;

  logic [31:0]  rdata_a, rdata_b, export_a, export_b;
  logic         start_a, start_b;
  logic [127:0] key_a, key_b, enc_a, enc_b;
  logic [1:0]   dbg_a, dbg_b;

  int n_checks = 0;
  int n_errors = 0;
  int run_cnt_b = 0;

  localparam logic [127:0] KEY  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] ENC  = 128'hdaec3055df058e1c39e814ea76f6747e;
  localparam logic [127:0] DEC1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] DEC2 = 128'hfedcba98765432100123456789abcdef;

  aes_avalon_ctrl u_dut (
    .CLK(clk), .RESET_N(rst_n), .AVL_CS(cs), .AVL_READ(rd), .AVL_WRITE(wr),
    .AVL_ADDR(addr), .AVL_BYTE_EN(be), .AVL_WRITEDATA(wdata), .AVL_READDATA(rdata_a),
    .EXPORT_DATA(export_a), .AES_START(start_a), .AES_DONE(done_a), .AES_KEY(key_a),
    .AES_MSG_ENC(enc_a), .AES_MSG_DEC(msg_dec), .o_dbg_state(dbg_a)
  );

  aes_avalon_ctrl #(.TIMEOUT(16)) u_tmo (
    .CLK(clk), .RESET_N(rst_n), .AVL_CS(cs), .AVL_READ(rd), .AVL_WRITE(wr),
    .AVL_ADDR(addr), .AVL_BYTE_EN(be), .AVL_WRITEDATA(wdata), .AVL_READDATA(rdata_b),
    .EXPORT_DATA(export_b), .AES_START(start_b), .AES_DONE(done_b), .AES_KEY(key_b),
    .AES_MSG_ENC(enc_b), .AES_MSG_DEC(msg_dec), .o_dbg_state(dbg_b)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (start_b) run_cnt_b++;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Driver tasks: entered and left on a falling edge, one bus cycle each
  task automatic bus_write(input logic [3:0] a, input logic [3:0] b, input logic [31:0] d);
    cs = 1'b1; wr = 1'b1; rd = 1'b0; addr = a; be = b; wdata = d;
    @(negedge clk);
    cs = 1'b0; wr = 1'b0;
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [31:0] qa, output logic [31:0] qb);
    cs = 1'b1; rd = 1'b1; wr = 1'b0; addr = a;
    @(negedge clk);
    cs = 1'b0; rd = 1'b0;
    qa = rdata_a; qb = rdata_b;
  endtask

  task automatic bus_rw(input logic [3:0] a, input logic [31:0] d, output logic [31:0] qa);
    cs = 1'b1; rd = 1'b1; wr = 1'b1; addr = a; be = 4'hf; wdata = d;
    @(negedge clk);
    cs = 1'b0; rd = 1'b0; wr = 1'b0;
    qa = rdata_a;
  endtask

  task automatic pulse_done(input logic which_b, input logic [127:0] m);
    msg_dec = m;
    if (which_b) done_b = 1'b1; else done_a = 1'b1;
    @(negedge clk);
    done_a = 1'b0; done_b = 1'b0;
  endtask

  logic [31:0] qa, qb;

  initial begin
    rst_n = 1'b0; cs = 1'b0; rd = 1'b0; wr = 1'b0; addr = '0; be = '0; wdata = '0;
    done_a = 1'b0; done_b = 1'b0; msg_dec = '0;
    repeat (3) @(negedge clk);
    check("rst_rdata", rdata_a, 0);
    check("rst_start", start_a, 0);
    check("rst_export", export_a, 0);
    check("rst_key", key_a, 0);
    check("rst_state", dbg_a, 0);
    rst_n = 1'b1;
    @(negedge clk);
    bus_read(4'd15, qa, qb); check("rst_status", qa, 0);

    // Partial byte-enable write, then full key/ciphertext load
    bus_write(4'd0, 4'b0101, 32'hffffffff);
    bus_read(4'd0, qa, qb); check("be_0101", qa, 32'h00ff00ff);
    for (int i = 0; i < 4; i++) bus_write(4'(i), 4'hf, KEY[127 - 32*i -: 32]);
    for (int i = 0; i < 4; i++) bus_write(4'(i + 4), 4'hf, ENC[127 - 32*i -: 32]);
    check("aes_key", key_a, KEY);
    check("aes_msg_enc", enc_a, ENC);
    check("export", export_a, 32'h00010e0f);
    bus_rw(4'd4, 32'h11111111, qa); check("rw_prewrite", qa, 32'hdaec3055);
    bus_read(4'd4, qa, qb); check("rw_postwrite", qa, 32'h11111111);
    bus_write(4'd4, 4'hf, 32'hdaec3055);
    bus_write(4'd13, 4'hf, 32'hdeadbeef);
    bus_read(4'd13, qa, qb); check("reserved_rd", qa, 0);
    repeat (2) @(negedge clk);
    check("rdata_hold", rdata_a, 0);
    bus_write(4'd9, 4'hf, 32'hdeadbeef);
    bus_read(4'd9, qa, qb); check("ro_dec_wr", qa, 0);

    // Normal decrypt on u_dut; u_tmo runs in parallel and times out
    bus_write(4'd14, 4'h1, 32'h1);
    check("start_hi", start_a, 1);
    bus_read(4'd15, qa, qb); check("status_busy", qa, 2); check("status_busy_b", qb, 2);
    bus_write(4'd0, 4'b0101, 32'hffffffff);
    bus_read(4'd0, qa, qb); check("busy_wr_ign", qa, 32'h00010203);
    repeat (16) @(negedge clk);
    pulse_done(1'b0, DEC1);
    check("start_lo", start_a, 0);
    for (int i = 0; i < 4; i++) begin
      bus_read(4'(i + 8), qa, qb);
      check("dec_cap", qa, {96'd0, DEC1[127 - 32*i -: 32]});
    end
    bus_read(4'd15, qa, qb); check("status_done", qa, 1); check("status_tmo_b", qb, 4);
    bus_read(4'd14, qa, qb); check("ctrl_a", qa, 1); check("ctrl_tmo_b", qb, 0);
    check("tmo_run_cycles", run_cnt_b, 16);
    pulse_done(1'b1, DEC2);
    bus_read(4'd8, qa, qb); check("done_idle_ign", qb, 0);
    bus_read(4'd15, qa, qb); check("status_idle_b", qb, 4);

    // DONE -> IDLE on CTRL=0
    bus_write(4'd14, 4'h1, 32'h0);
    bus_read(4'd15, qa, qb); check("done_clr", qa, 0);

    // AES_DONE exactly on the terminal count of u_tmo
    bus_write(4'd14, 4'h1, 32'h1);
    bus_read(4'd15, qa, qb); check("tmo_clr_b", qb, 2);
    repeat (14) @(negedge clk);
    pulse_done(1'b1, DEC2);
    check("start_lo_b", start_b, 0);
    bus_read(4'd15, qa, qb); check("coincide_status", qb, 1); check("still_busy_a", qa, 2);
    bus_read(4'd8, qa, qb); check("coincide_cap", qb, 32'hfedcba98);
    bus_write(4'd14, 4'h1, 32'h1);
    bus_read(4'd15, qa, qb); check("done_rerun_b", qb, 2); check("run_start1_ign", qa, 2);
    bus_write(4'd14, 4'h1, 32'h0);
    pulse_done(1'b0, DEC2);
    bus_read(4'd15, qa, qb); check("abort_status", qa, 0); check("abort_status_b", qb, 0);
    bus_read(4'd14, qa, qb); check("abort_ctrl", qa, 0);
    bus_read(4'd8, qa, qb); check("abort_nocap", qa, 32'h00112233);

    // Reset in RUN with a coincident AES_DONE
    bus_write(4'd14, 4'h1, 32'h1);
    repeat (3) @(negedge clk);
    rst_n = 1'b0; done_a = 1'b1; msg_dec = DEC2;
    @(negedge clk);
    rst_n = 1'b1; done_a = 1'b0;
    check("rstrun_start", start_a, 0);
    check("rstrun_rdata", rdata_a, 0);
    check("rstrun_export", export_a, 0);
    for (int i = 0; i < 16; i++) begin
      bus_read(4'(i), qa, qb);
      check("rstrun_reg", qa, 0);
    end
    bus_write(4'd14, 4'h1, 32'h1);
    check("restart_start", start_a, 1);
    repeat (5) @(negedge clk);
    pulse_done(1'b0, DEC1);
    bus_read(4'd15, qa, qb); check("restart_status", qa, 1);
    bus_read(4'd11, qa, qb); check("restart_cap", qa, 32'hccddeeff);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
